gshare_predictor: RTL and testbench

- Next-generation branch direction predictor for the 5-stage RV32 pipeline.
- Pattern history table (PHT) of saturating counters, indexed by PC bits XOR a global history register (GHR).
- Prediction is read in IF. Update arrives from MEM with the GHR snapshot taken at prediction time; on a mispredict the speculative GHR is repaired.
- Reset clears the table with a sequential sweep, and performance counters track branches and mispredicts.

---
 rtl/bp_pkg.sv | 33 +++
 rtl/gshare_predictor_if.sv | 29 ++
 rtl/bp_counter_table.sv | 72 +++++++
 rtl/gshare_predictor.sv | 70 +++++++
 tb/tb_gshare_predictor.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/bp_pkg.sv
// Shared types and helpers for the gshare branch predictor.
package bp_pkg;

    localparam logic [1:0] STRONG_NT = 2'd0;
    localparam logic [1:0] WEAK_NT   = 2'd1;
    localparam logic [1:0] WEAK_T    = 2'd2;
    localparam logic [1:0] STRONG_T  = 2'd3;

    // Widest counter the helpers support; callers zero-extend into this width.
    localparam int CTR_MAX_W = 8;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } bp_state_e;

    function automatic logic [CTR_MAX_W-1:0] sat_inc(input logic [CTR_MAX_W-1:0] c, input int w);
        logic [CTR_MAX_W-1:0] mx;
        mx = CTR_MAX_W'((1 << w) - 1);
        return (c >= mx) ? mx : c + 1'b1;
    endfunction

    function automatic logic [CTR_MAX_W-1:0] sat_dec(input logic [CTR_MAX_W-1:0] c, input int w);
        return (c == '0) ? c : c - 1'b1;
    endfunction

    // PC bits starting at pc_lsb XOR zero-extended history, masked to idx_w bits.
    function automatic logic [31:0] idx_hash(input logic [31:0] pc, input logic [31:0] ghr,
                                             input int pc_lsb, input int idx_w);
        return ((pc >> pc_lsb) ^ ghr) & ((32'd1 << idx_w) - 32'd1);
    endfunction

endpackage

// File: rtl/gshare_predictor_if.sv
// Lookup/update/status bundle between the pipeline and the predictor.
interface gshare_predictor_if #(
    parameter int CTR_W = 2,
    parameter int GHR_W = 8
);
    logic             pred_valid;
    logic [31:0]      pred_pc;
    logic             pred_taken;
    logic [CTR_W-1:0] pred_ctr;
    logic [GHR_W-1:0] pred_ghr;
    logic             upd_valid;
    logic [31:0]      upd_pc;
    logic [GHR_W-1:0] upd_ghr;
    logic             upd_taken;
    logic             upd_mispredict;
    logic             init_busy;
    logic [31:0]      perf_branches;
    logic [31:0]      perf_mispredicts;

    modport master (
        output pred_valid, pred_pc, upd_valid, upd_pc, upd_ghr, upd_taken, upd_mispredict,
        input  pred_taken, pred_ctr, pred_ghr, init_busy, perf_branches, perf_mispredicts
    );

    modport slave (
        input  pred_valid, pred_pc, upd_valid, upd_pc, upd_ghr, upd_taken, upd_mispredict,
        output pred_taken, pred_ctr, pred_ghr, init_busy, perf_branches, perf_mispredicts
    );
endinterface

// File: rtl/bp_counter_table.sv
// Pattern history table: async read, read-modify-write saturating update,
// and a one-entry-per-cycle initialisation sweep after reset.
//
//   state   | meaning
//   ST_INIT | sweeping entries with INIT_CTR, reads not valid
//   ST_RUN  | normal operation, updates honoured
module bp_counter_table
    import bp_pkg::*;
#(
    parameter int ENTRIES  = 256,
    parameter int CTR_W    = 2,
    parameter int INIT_CTR = 1,
    localparam int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [CTR_W-1:0] rd_ctr,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken,
    output logic             init_busy
);
    logic [CTR_W-1:0] mem [ENTRIES];
    bp_state_e        state;
    logic [IDX_W-1:0] sweep;

    logic                 mem_we;
    logic [IDX_W-1:0]     mem_addr;
    logic [CTR_W-1:0]     mem_data;
    logic [CTR_MAX_W-1:0] cur_ext;
    logic [CTR_MAX_W-1:0] nxt_ext;

    assign rd_ctr    = mem[rd_idx];
    assign init_busy = (state == ST_INIT);

    // Select between sweep writes and saturating counter updates.
    always_comb begin
        cur_ext  = CTR_MAX_W'(mem[wr_idx]);
        nxt_ext  = wr_taken ? sat_inc(cur_ext, CTR_W) : sat_dec(cur_ext, CTR_W);
        mem_we   = 1'b0;
        mem_addr = wr_idx;
        mem_data = nxt_ext[CTR_W-1:0];
        if (!rst) begin
            if (state == ST_INIT) begin
                mem_we   = 1'b1;
                mem_addr = sweep;
                mem_data = CTR_W'(INIT_CTR);
            end else if (wr_en) begin
                mem_we = 1'b1;
            end
        end
    end

    // Table storage write port.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_addr] <= mem_data;
    end

    // Init sweep sequencing; last entry written moves to ST_RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_INIT;
            sweep <= '0;
        end else if (state == ST_INIT) begin
            sweep <= sweep + 1'b1;
            if (sweep == IDX_W'(ENTRIES - 1))
                state <= ST_RUN;
        end
    end
endmodule

// File: rtl/gshare_predictor.sv
// Gshare direction predictor: speculative GHR with mispredict repair,
// PHT lookup/update and saturating performance counters.
module gshare_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES  = 256,
    parameter int CTR_W    = 2,
    parameter int GHR_W    = 8,
    parameter int PC_LSB   = 2,
    parameter int INIT_CTR = 1,
    localparam int IDX_W   = $clog2(ENTRIES)
) (
    input  logic              clk,
    input  logic              rst,
    gshare_predictor_if.slave bus
);
    logic [GHR_W-1:0] ghr;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic [CTR_W-1:0] rd_ctr;
    logic             busy;
    logic             upd_acc;

    assign rd_idx  = IDX_W'(idx_hash(bus.pred_pc, 32'(ghr), PC_LSB, IDX_W));
    assign wr_idx  = IDX_W'(idx_hash(bus.upd_pc, 32'(bus.upd_ghr), PC_LSB, IDX_W));
    assign upd_acc = bus.upd_valid & ~busy;

    bp_counter_table #(
        .ENTRIES  (ENTRIES),
        .CTR_W    (CTR_W),
        .INIT_CTR (INIT_CTR)
    ) u_table (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (rd_idx),
        .rd_ctr    (rd_ctr),
        .wr_en     (upd_acc),
        .wr_idx    (wr_idx),
        .wr_taken  (bus.upd_taken),
        .init_busy (busy)
    );

    assign bus.init_busy  = busy;
    assign bus.pred_ctr   = busy ? '0 : rd_ctr;
    assign bus.pred_taken = bus.pred_ctr[CTR_W-1];
    assign bus.pred_ghr   = busy ? '0 : ghr;

    // History: repair from the MEM snapshot wins over the IF speculative shift.
    always_ff @(posedge clk) begin
        if (rst || busy)
            ghr <= '0;
        else if (upd_acc && bus.upd_mispredict)
            ghr <= (bus.upd_ghr << 1) | GHR_W'(bus.upd_taken);
        else if (bus.pred_valid)
            ghr <= (ghr << 1) | GHR_W'(bus.pred_taken);
    end

    // Saturating branch and mispredict counters over accepted updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.perf_branches    <= '0;
            bus.perf_mispredicts <= '0;
        end else if (upd_acc) begin
            if (bus.perf_branches != 32'hFFFF_FFFF)
                bus.perf_branches <= bus.perf_branches + 32'd1;
            if (bus.upd_mispredict && bus.perf_mispredicts != 32'hFFFF_FFFF)
                bus.perf_mispredicts <= bus.perf_mispredicts + 32'd1;
        end
    end
endmodule

// File: tb/tb_gshare_predictor.sv
// Directed bench for gshare_predictor with hand-computed expectations.
module tb_gshare_predictor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n;

    always #5 clk = ~clk;

    gshare_predictor_if #(.CTR_W(2), .GHR_W(8)) bus ();

    gshare_predictor #(
        .ENTRIES (256), .CTR_W (2), .GHR_W (8), .PC_LSB (2), .INIT_CTR (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.pred_valid     = 1'b0;
        bus.upd_valid      = 1'b0;
        bus.upd_mispredict = 1'b0;
        bus.upd_taken      = 1'b0;
    endtask

    task automatic upd(input logic [31:0] pc, input logic [7:0] g, input logic t, input logic m);
        bus.upd_valid      = 1'b1;
        bus.upd_pc         = pc;
        bus.upd_ghr        = g;
        bus.upd_taken      = t;
        bus.upd_mispredict = m;
    endtask

    task automatic count_busy(input string tag, input int exp);
        n = 0;
        while (bus.init_busy === 1'b1 && n < 1000) begin
            n++;
            cyc();
        end
        chk(tag, n, exp);
    endtask

    initial begin
        bus.pred_pc = '0;
        bus.upd_pc  = '0;
        bus.upd_ghr = '0;
        idle();

        // Reset held for three cycles
        cyc();
        chk("rst_busy", {31'd0, bus.init_busy}, 1);
        chk("rst_ctr", {30'd0, bus.pred_ctr}, 0);
        chk("rst_taken", {31'd0, bus.pred_taken}, 0);
        chk("rst_ghr", {24'd0, bus.pred_ghr}, 0);
        chk("rst_perf_b", bus.perf_branches, 0);
        chk("rst_perf_m", bus.perf_mispredicts, 0);
        cyc();
        cyc();
        rst = 1'b0;
        count_busy("sweep_len", 256);
        chk("sweep_done", {31'd0, bus.init_busy}, 0);

        // Every entry initialised weakly not-taken
        n = 0;
        for (int i = 0; i < 256; i++) begin
            bus.pred_pc = 32'(i) << 2;
            #1;
            if (bus.pred_ctr !== 2'd1 || bus.pred_taken !== 1'b0) n++;
        end
        chk("init_all_entries_bad", n, 0);

        // Saturation at pc 0x40 (index 0x10)
        bus.pred_pc = 32'h40;
        #1;
        chk("sat_start", {30'd0, bus.pred_ctr}, 1);
        upd(32'h40, 8'h00, 1'b1, 1'b0); cyc();
        chk("sat_inc1", {30'd0, bus.pred_ctr}, 2);
        chk("sat_taken1", {31'd0, bus.pred_taken}, 1);
        cyc(); chk("sat_inc2", {30'd0, bus.pred_ctr}, 3);
        cyc(); chk("sat_inc3", {30'd0, bus.pred_ctr}, 3);
        cyc(); chk("sat_inc4", {30'd0, bus.pred_ctr}, 3);
        upd(32'h40, 8'h00, 1'b0, 1'b0); cyc();
        chk("sat_dec1", {30'd0, bus.pred_ctr}, 2);
        cyc(); chk("sat_dec2", {30'd0, bus.pred_ctr}, 1);
        chk("sat_taken_dec2", {31'd0, bus.pred_taken}, 0);
        cyc(); chk("sat_dec3", {30'd0, bus.pred_ctr}, 0);
        cyc(); chk("sat_dec4", {30'd0, bus.pred_ctr}, 0);
        cyc(); chk("sat_dec5", {30'd0, bus.pred_ctr}, 0);
        idle();
        #1;
        chk("perf_b_9", bus.perf_branches, 9);
        chk("perf_m_0", bus.perf_mispredicts, 0);

        // Train every entry to strongly taken
        for (int i = 0; i < 256; i++) begin
            for (int k = 0; k < 3; k++) begin
                upd(32'(i) << 2, 8'h00, 1'b1, 1'b0);
                cyc();
            end
        end
        idle();
        #1;
        chk("trained_0x10", {30'd0, bus.pred_ctr}, 3);
        chk("perf_b_777", bus.perf_branches, 777);

        // Speculative GHR shifts
        bus.pred_pc = 32'h100;
        bus.pred_valid = 1'b1;
        #1;
        chk("spec_ghr0", {24'd0, bus.pred_ghr}, 8'h00);
        chk("spec_taken0", {31'd0, bus.pred_taken}, 1);
        cyc(); chk("spec_ghr1", {24'd0, bus.pred_ghr}, 8'h01);
        cyc(); chk("spec_ghr2", {24'd0, bus.pred_ghr}, 8'h03);
        cyc(); chk("spec_ghr3", {24'd0, bus.pred_ghr}, 8'h07);

        // Mispredict repair overrides same-cycle speculative shift
        upd(32'h200, 8'h05, 1'b0, 1'b1);
        cyc();
        idle();
        #1;
        chk("repair_ghr", {24'd0, bus.pred_ghr}, 8'h0A);
        chk("repair_perf_b", bus.perf_branches, 778);
        chk("repair_perf_m", bus.perf_mispredicts, 1);

        // Force ghr to 0 via repair (touches index 0xFF only)
        upd(32'h3FC, 8'h00, 1'b0, 1'b1); cyc();
        idle();
        #1;
        chk("ghr_zero", {24'd0, bus.pred_ghr}, 8'h00);
        // Decrement index 0 through pc 0x04 / ghr 0x01, read it back through pc 0x00 / ghr 0
        upd(32'h04, 8'h01, 1'b0, 1'b0); cyc();
        idle();
        bus.pred_pc = 32'h00;
        #1;
        chk("alias_pc0_g0", {30'd0, bus.pred_ctr}, 2);
        // Set ghr to 1 via repair (taken at index 0xFE, already saturated)
        upd(32'h3F8, 8'h00, 1'b1, 1'b1); cyc();
        idle();
        bus.pred_pc = 32'h04;
        #1;
        chk("ghr_one", {24'd0, bus.pred_ghr}, 8'h01);
        chk("alias_pc4_g1", {30'd0, bus.pred_ctr}, 2);
        bus.pred_pc = 32'h00;
        #1;
        chk("idx1_pc0_g1", {30'd0, bus.pred_ctr}, 3);
        // Same-cycle read and write of index 1
        upd(32'h04, 8'h00, 1'b0, 1'b0);
        #1;
        chk("rw_old", {30'd0, bus.pred_ctr}, 3);
        cyc();
        idle();
        #1;
        chk("rw_new", {30'd0, bus.pred_ctr}, 2);
        chk("perf_b_782", bus.perf_branches, 782);
        chk("perf_m_3", bus.perf_mispredicts, 3);

        // Reset mid-sweep at count 100
        rst = 1'b1; cyc();
        chk("rst2_perf_b", bus.perf_branches, 0);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) cyc();
        chk("mid_busy", {31'd0, bus.init_busy}, 1);
        rst = 1'b1; cyc();
        rst = 1'b0;
        // Updates during the sweep are ignored
        upd(32'h200, 8'h05, 1'b1, 1'b1);
        bus.pred_valid = 1'b1;
        count_busy("resweep_len", 256);
        idle();
        #1;
        chk("resweep_perf_b", bus.perf_branches, 0);
        chk("resweep_perf_m", bus.perf_mispredicts, 0);
        chk("resweep_ghr", {24'd0, bus.pred_ghr}, 8'h00);
        bus.pred_pc = 32'h218;
        #1;
        chk("resweep_entry", {30'd0, bus.pred_ctr}, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
